// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encoding and width constants for the shared integer ALU
package alu_pkg;

  localparam int ALU_OP_LAST = 9;
  localparam int DATA_W_C    = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

endpackage

// File: rtl/alu_bitwise.sv
// rtl/alu_bitwise.sv - bitwise logic units shared by the ALU core
module alu_xor #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);
  assign o_y = i_a ^ i_b;
endmodule

module alu_or #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);
  assign o_y = i_a | i_b;
endmodule

module alu_and #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);
  assign o_y = i_a & i_b;
endmodule

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational integer ALU: (op, a, b) -> (result, illegal)
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0]          i_op,
  input  logic [DATA_W_C-1:0] i_a,
  input  logic [DATA_W_C-1:0] i_b,
  output logic [DATA_W_C-1:0] o_result,
  output logic                o_illegal
);

  logic [DATA_W_C-1:0] xor_y;
  logic [DATA_W_C-1:0] or_y;
  logic [DATA_W_C-1:0] and_y;
  logic [4:0]          shamt;

  assign shamt = i_b[4:0];

  alu_xor #(.W(DATA_W_C)) u_xor (.i_a(i_a), .i_b(i_b), .o_y(xor_y));
  alu_or  #(.W(DATA_W_C)) u_or  (.i_a(i_a), .i_b(i_b), .o_y(or_y));
  alu_and #(.W(DATA_W_C)) u_and (.i_a(i_a), .i_b(i_b), .o_y(and_y));

  always_comb begin
    o_result  = '0;
    o_illegal = 1'b0;
    case (i_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_SLL:  o_result = i_a << shamt;
      ALU_SLT:  o_result = {31'd0, $signed(i_a) < $signed(i_b)};
      ALU_SLTU: o_result = {31'd0, i_a < i_b};
      ALU_XOR:  o_result = xor_y;
      ALU_SRL:  o_result = i_a >> shamt;
      ALU_SRA:  o_result = DATA_W_C'($signed(i_a) >>> shamt);
      ALU_OR:   o_result = or_y;
      ALU_AND:  o_result = and_y;
      // codes above ALU_OP_LAST still retire, with a zero result
      default:  o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin arbiter sharing one ALU core among NUM_REQ requesters
module alu_share_arb
  import alu_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int DATA_W  = DATA_W_C,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  output logic [NUM_REQ-1:0]              o_req_ready,
  input  logic [NUM_REQ-1:0][3:0]         i_req_op,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  i_req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  i_req_b,
  output logic                            o_rsp_valid,
  input  logic                            i_rsp_ready,
  output logic [DATA_W-1:0]               o_rsp_data,
  output logic [ID_W-1:0]                 o_rsp_id,
  output logic                            o_rsp_err
);

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;

  logic              accept_en;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   next_ptr;
  logic              xfer;
  logic [3:0]        sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_illegal;

  assign accept_en = !rsp_valid_q || i_rsp_ready;

  // Walk from rr_ptr upward; iterating in reverse lets the nearest valid win.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (i_req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  always_comb begin
    o_req_ready = '0;
    if (grant_vld && accept_en && i_rst_n) begin
      o_req_ready[grant_id] = 1'b1;
    end
  end

  assign xfer   = grant_vld && accept_en && i_rst_n;
  assign sel_op = i_req_op[grant_id];
  assign sel_a  = i_req_a[grant_id];
  assign sel_b  = i_req_b[grant_id];

  alu_core u_alu_core (
    .i_op      (sel_op),
    .i_a       (sel_a),
    .i_b       (sel_b),
    .o_result  (alu_result),
    .o_illegal (alu_illegal)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = alu_result;
      rsp_id_d    = grant_id;
      rsp_err_d   = alu_illegal;
      rr_ptr_d    = next_ptr;
    end else if (rsp_valid_q && i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed self-checking bench for alu_share_arb
module tb_alu_share_arb;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][3:0]   req_op;
  logic [1:0][31:0]  req_a;
  logic [1:0][31:0]  req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [0:0]        rsp_id;
  logic              rsp_err;

  int tests_run;
  int tests_failed;

  alu_share_arb #(.NUM_REQ(2), .DATA_W(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_op    (req_op),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_id    (rsp_id),
    .o_rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    #12;
    tests_run++;
    if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
    tests_run++;
    if (rsp_data !== 32'h0) begin tests_failed++; $display("FAIL reset_data got %h exp 0", rsp_data); end
    tests_run++;
    if (rsp_id !== 1'b0 || rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_id_err got id=%b err=%b exp 0/0", rsp_id, rsp_err); end
    tests_run++;
    if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_ready got %b exp 00", req_ready); end
    req_valid = 2'b00;
    rst_n     = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_data;
    step();
    req_op[0] = 4'd0; req_a[0] = 32'd1;  req_b[0] = 32'd2;
    req_op[1] = 4'd0; req_a[1] = 32'd10; req_b[1] = 32'd20;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        tests_failed++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      step();
      exp_data = (k % 2 == 0) ? 32'd3 : 32'd30;
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'(k % 2) || rsp_data !== exp_data) begin
        tests_failed++; $display("FAIL rr_rsp[%0d] got v=%b id=%b d=%h exp v=1 id=%0d d=%h", k, rsp_valid, rsp_id, rsp_data, k % 2, exp_data);
      end
    end
    req_valid = 2'b00;
    step();
    tests_run++;
    if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_drain got %b exp 0", rsp_valid); end
  endtask

  task automatic test_single_xor();
    req_op[0] = 4'd5; req_a[0] = 32'hFFFF0000; req_b[0] = 32'h0F0F0F0F;
    req_valid = 2'b01;
    #1;
    tests_run++;
    if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL xor_ready got %b exp 01", req_ready); end
    step();
    req_valid = 2'b00;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hF0F00F0F || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
      tests_failed++; $display("FAIL xor_rsp got v=%b d=%h id=%b e=%b exp v=1 d=f0f00f0f id=0 e=0", rsp_valid, rsp_data, rsp_id, rsp_err);
    end
    step();
    tests_run++;
    if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL xor_drain got %b exp 0", rsp_valid); end
  endtask

  task automatic test_illegal();
    req_op[1] = 4'hF; req_a[1] = 32'h5; req_b[1] = 32'h6;
    req_valid = 2'b10;
    #1;
    tests_run++;
    if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL illegal_ready got %b exp 10", req_ready); end
    step();
    req_valid = 2'b00;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0 || rsp_err !== 1'b1 || rsp_id !== 1'b1) begin
      tests_failed++; $display("FAIL illegal_rsp got v=%b d=%h e=%b id=%b exp v=1 d=0 e=1 id=1", rsp_valid, rsp_data, rsp_err, rsp_id);
    end
    step();
    tests_run++;
    if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL illegal_drain got %b exp 0", rsp_valid); end
  endtask

  task automatic test_arith_corners();
    logic [3:0]  v_op  [8];
    logic [31:0] v_a   [8];
    logic [31:0] v_b   [8];
    logic [31:0] v_exp [8];
    v_op[0] = 4'd7; v_a[0] = 32'h80000000; v_b[0] = 32'h21;       v_exp[0] = 32'hC0000000;
    v_op[1] = 4'd3; v_a[1] = 32'hFFFFFFFF; v_b[1] = 32'h1;        v_exp[1] = 32'h1;
    v_op[2] = 4'd4; v_a[2] = 32'hFFFFFFFF; v_b[2] = 32'h1;        v_exp[2] = 32'h0;
    v_op[3] = 4'd0; v_a[3] = 32'hFFFFFFFF; v_b[3] = 32'h1;        v_exp[3] = 32'h0;
    v_op[4] = 4'd1; v_a[4] = 32'h0;        v_b[4] = 32'h1;        v_exp[4] = 32'hFFFFFFFF;
    v_op[5] = 4'd2; v_a[5] = 32'h1;        v_b[5] = 32'h3F;       v_exp[5] = 32'h80000000;
    v_op[6] = 4'd6; v_a[6] = 32'h80000000; v_b[6] = 32'h4;        v_exp[6] = 32'h08000000;
    v_op[7] = 4'd9; v_a[7] = 32'hF0F0AAAA; v_b[7] = 32'h0FF0FF00; v_exp[7] = 32'h00F0AA00;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_op[0] = v_op[i]; req_a[0] = v_a[i]; req_b[0] = v_b[i];
      req_valid = 2'b01;
      step();
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_data !== v_exp[i] || rsp_err !== 1'b0 || rsp_id !== 1'b0) begin
        tests_failed++; $display("FAIL arith[%0d] op=%0d got v=%b d=%h e=%b exp v=1 d=%h e=0", i, v_op[i], rsp_valid, rsp_data, rsp_err, v_exp[i]);
      end
    end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b1;
    req_op[0] = 4'd0; req_a[0] = 32'd7; req_b[0] = 32'd8;
    req_valid = 2'b01;
    step();
    rsp_ready = 1'b0;
    req_op[1] = 4'd1; req_a[1] = 32'd100; req_b[1] = 32'd1;
    req_valid = 2'b10;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL bp_ready[%0d] got %b exp 00", c, req_ready); end
      step();
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd15 || rsp_id !== 1'b0) begin
        tests_failed++; $display("FAIL bp_hold[%0d] got v=%b d=%h id=%b exp v=1 d=f id=0", c, rsp_valid, rsp_data, rsp_id);
      end
    end
    rsp_ready = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL bp_release_ready got %b exp 10", req_ready); end
    step();
    req_valid = 2'b00;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd99 || rsp_id !== 1'b1) begin
      tests_failed++; $display("FAIL bp_new_rsp got v=%b d=%h id=%b exp v=1 d=63 id=1", rsp_valid, rsp_data, rsp_id);
    end
    step();
    tests_run++;
    if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drain got %b exp 0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    req_op[0] = 4'd8; req_a[0] = 32'h00F0; req_b[0] = 32'h0F00;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0FF0) begin
      tests_failed++; $display("FAIL rstmid_pending got v=%b d=%h exp v=1 d=0ff0", rsp_valid, rsp_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin
      tests_failed++; $display("FAIL rstmid_drop got v=%b d=%h exp v=0 d=0", rsp_valid, rsp_data);
    end
    req_op[1] = 4'd0; req_a[1] = 32'd1; req_b[1] = 32'd1;
    req_op[0] = 4'd0; req_a[0] = 32'd2; req_b[0] = 32'd2;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL rstmid_ready_in_reset got %b exp 00", req_ready); end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL rstmid_first_grant got %b exp 01", req_ready); end
    step();
    req_valid = 2'b00;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd4) begin
      tests_failed++; $display("FAIL rstmid_first_rsp got v=%b id=%b d=%h exp v=1 id=0 d=4", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_round_robin();
    test_single_xor();
    test_illegal();
    test_arith_corners();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Shared-ALU arbiter and sequencer for the integer datapath. Up to NUM_REQ requesters (e.g. execute stage, address-generation helper) issue ALU operations over a valid/ready handshake. A round-robin arbiter grants one request per cycle to a single instance of the combinational ALU core. The result is registered into one response channel tagged with the requester ID, with output backpressure.

## Interface
- NUM_REQ, default 2: number of requesters, 2..8.
- DATA_W, default 32: operand/result width; only 32 is supported.
- ID_W, derived as $clog2(NUM_REQ): requester tag width; not overridable.

- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- o_req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- i_req_op  in  NUM_REQ x 4  per-requester opcode, alu_pkg encoding.
- i_req_a  in  NUM_REQ x DATA_W  operand A per requester.
- i_req_b  in  NUM_REQ x DATA_W  operand B per requester.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  consumer accepts response.
- o_rsp_data  out  DATA_W  registered ALU result.
- o_rsp_id  out  ID_W  index of the requester that issued the result.
- o_rsp_err  out  1  opcode was illegal.

## Operation
- Opcodes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9. Codes 10–15 are illegal.
- Shifts use i_req_b[4:0] only. SLT is signed and SLTU unsigned; both return 32'h1 or 32'h0. ADD/SUB wrap modulo 2^32 with no flags.
- An illegal opcode returns o_rsp_data=0 with o_rsp_err=1. The request is still consumed.
- Output register slot: accept_en = !o_rsp_valid || i_rsp_ready.
- Arbitration: rr_ptr (ID_W bits) is the highest-priority index. Scan rr_ptr, rr_ptr+1, … modulo NUM_REQ; the first valid requester is the grant g.
- o_req_ready[g] = accept_en, computed combinationally. All other ready bits are 0. Ready does not depend on g's own valid except through selection.
- Transfer on valid[g] && ready[g]. On that edge:
  - o_rsp_data/o_rsp_err take the ALU output for g.
  - o_rsp_id takes g, and o_rsp_valid goes to 1.
  - rr_ptr takes (g+1) mod NUM_REQ, wrapping correctly for non-power-of-2 NUM_REQ.
- Response consumed (o_rsp_valid && i_rsp_ready) with no new transfer: o_rsp_valid goes to 0. With a simultaneous transfer, o_rsp_valid stays 1 and the new data loads.
- No transfer: rr_ptr holds.
- While o_rsp_valid=1 and i_rsp_ready=0, o_rsp_data/id/err stay stable.
- Reset values, applied asynchronously:
  - o_rsp_valid=0, o_rsp_data=0, o_rsp_id=0, o_rsp_err=0, rr_ptr=0.
  - o_req_ready=0 while i_rst_n=0.
- Reset mid-transaction discards any pending response.

## Timing
- Latency is 1 cycle from the accept edge to o_rsp_valid.
- Throughput is 1 op/cycle while i_rsp_ready=1.
- The combinational path runs i_req_* → mux → ALU → result register; no other logic sits in series.
- Requesters must hold valid/op/a/b stable until accepted. No hazard or ordering exists across requesters beyond arbitration order.
- A response is never dropped or duplicated.

## Structure
- alu_pkg: alu_op_e (4-bit enum above) and the constants ALU_OP_LAST=9 and DATA_W_C=32.
- Sub-module alu_core: purely combinational (op, a, b) → (result, illegal). It reuses the existing bitwise units (alu_xor etc.) internally.
- alu_share_arb holds the round-robin arbiter, operand mux, output register and rr_ptr.

## Test plan
- Single XOR: req0 a=0xFFFF0000, b=0x0F0F0F0F, op=5 → next cycle o_rsp_valid=1, data=0xF0F00F0F, id=0, err=0.
- Both requesters valid continuously with rsp_ready=1 after reset → grants 0,1,0,1; rsp_id alternates and one response arrives per cycle.
- Backpressure: hold rsp_ready=0 for 3 cycles with a response pending.
  - o_req_ready=0 and data stays stable.
  - Raise rsp_ready: the pending response is consumed and a new request is accepted in the same cycle.
- Illegal op 4'hF from req1 → data=0, err=1, id=1, and the request is consumed.
- Arithmetic corners:
  - SRA 0x80000000 by b=0x21 → 0xC0000000.
  - SLT a=0xFFFFFFFF, b=1 → 1; SLTU on the same operands → 0.
  - ADD 0xFFFFFFFF+1 → 0.
- Reset: assert i_rst_n=0 mid-cycle with a response pending → o_rsp_valid drops immediately. After release, the first grant goes to req0.
